// File: rtl/spi_slave_responder.sv
// SPI responder: rebuilds frames from oversampled SCK/CS/MOSI in the CLK domain,
// returns the received word and shifts a preloaded reply word out on MISO.
module spi_slave_responder #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  spi_mode_in,
   input  logic [1:0]  word_len_in,
   input  logic [31:0] tx_data_in,
   input  logic        tx_load_in,
   input  logic        SCK_in,
   input  logic        CS_in,
   input  logic        MOSI_in,
   output logic        MISO_out,
   output logic [31:0] rx_data_out,
   output logic        rx_valid_out,
   output logic        busy_out,
   output logic        frame_err_out
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic sck_s, cs_s, mosi_s;
   logic sck_d, cs_d;

   logic              cpol_q, cpha_q, cpol_n, cpha_n;
   logic [1:0]        len_q, len_n;
   logic [DATA_W-1:0] tx_buf, tx_buf_n;
   logic [DATA_W-1:0] tx_shift, tx_shift_n;
   logic [DATA_W-1:0] rx_shift, rx_shift_n;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0] rx_data_n;
   logic              rx_valid_n, busy_n, frame_err_n, miso_n;

   logic              sck_rise, sck_fall, cs_rise, cs_fall;
   logic              lead_edge, trail_edge, sample_edge, shift_edge;
   logic [CNT_W-1:0]  frame_bits;
   logic [DATA_W-1:0] tx_aligned;

   // Pin synchronizers plus one-cycle-delayed copies for edge detection; CS idles high
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_in};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_in};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_in};
         sck_d     <= sck_s;
         cs_d      <= cs_s;
      end
   end

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sck_rise    = sck_s & ~sck_d;
   assign sck_fall    = ~sck_s & sck_d;
   assign cs_rise     = cs_s & ~cs_d;
   assign cs_fall     = ~cs_s & cs_d;
   assign lead_edge   = cpol_q ? sck_fall : sck_rise;
   assign trail_edge  = cpol_q ? sck_rise : sck_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge : trail_edge;

   // Frame length in bits for the latched word length
   always_comb begin
      frame_bits = CNT_W'(8);
      unique case (len_q)
         2'd0: frame_bits = CNT_W'(8);
         2'd1: frame_bits = CNT_W'(16);
         2'd2: frame_bits = CNT_W'(24);
         2'd3: frame_bits = CNT_W'(32);
         default: frame_bits = CNT_W'(8);
      endcase
   end

   // Reply word left-aligned so the MSB of the selected length sits in bit 31
   always_comb begin
      tx_aligned = tx_buf;
      unique case (word_len_in)
         2'd0: tx_aligned = {tx_buf[7:0],  24'h0};
         2'd1: tx_aligned = {tx_buf[15:0], 16'h0};
         2'd2: tx_aligned = {tx_buf[23:0], 8'h0};
         2'd3: tx_aligned = tx_buf;
         default: tx_aligned = tx_buf;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_n;
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_n     = state;
      cpol_n      = cpol_q;
      cpha_n      = cpha_q;
      len_n       = len_q;
      tx_shift_n  = tx_shift;
      rx_shift_n  = rx_shift;
      bit_cnt_n   = bit_cnt;
      rx_data_n   = rx_data_out;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;
      busy_n      = busy_out;
      miso_n      = MISO_out;
      tx_buf_n    = tx_load_in ? tx_data_in : tx_buf;

      unique case (state)
         IDLE: begin
            miso_n = 1'b0;
            busy_n = 1'b0;
            if (cs_fall) begin
               state_n    = ACTIVE;
               cpol_n     = spi_mode_in[1];
               cpha_n     = spi_mode_in[0];
               len_n      = word_len_in;
               bit_cnt_n  = '0;
               rx_shift_n = '0;
               busy_n     = 1'b1;
               tx_shift_n = tx_aligned;
               // CPHA=0 presents the first bit before any clock edge
               if (!spi_mode_in[0]) begin
                  miso_n     = tx_aligned[DATA_W-1];
                  tx_shift_n = {tx_aligned[DATA_W-2:0], 1'b0};
               end
            end
         end
         ACTIVE: begin
            // CS rise takes priority over a coincident sample edge
            if (cs_rise) begin
               state_n     = IDLE;
               frame_err_n = 1'b1;
               busy_n      = 1'b0;
               miso_n      = 1'b0;
            end else if (sample_edge) begin
               rx_shift_n = {rx_shift[DATA_W-2:0], mosi_s};
               bit_cnt_n  = bit_cnt + CNT_W'(1);
               if (bit_cnt + CNT_W'(1) == frame_bits) begin
                  rx_data_n  = {rx_shift[DATA_W-2:0], mosi_s};
                  rx_valid_n = 1'b1;
                  state_n    = DONE;
               end
            end else if (shift_edge) begin
               miso_n     = tx_shift[DATA_W-1];
               tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
            end
         end
         DONE: begin
            if (cs_rise) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               miso_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cpol_q        <= 1'b0;
         cpha_q        <= 1'b0;
         len_q         <= 2'd0;
         tx_buf        <= '0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         bit_cnt       <= '0;
         rx_data_out   <= '0;
         rx_valid_out  <= 1'b0;
         frame_err_out <= 1'b0;
         busy_out      <= 1'b0;
         MISO_out      <= 1'b0;
      end else begin
         cpol_q        <= cpol_n;
         cpha_q        <= cpha_n;
         len_q         <= len_n;
         tx_buf        <= tx_buf_n;
         tx_shift      <= tx_shift_n;
         rx_shift      <= rx_shift_n;
         bit_cnt       <= bit_cnt_n;
         rx_data_out   <= rx_data_n;
         rx_valid_out  <= rx_valid_n;
         frame_err_out <= frame_err_n;
         busy_out      <= busy_n;
         MISO_out      <= miso_n;
      end
   end

endmodule
